// File: rtl/sprite_collision_unit.sv
// Per-frame sprite collision detector: accumulates pairwise layer overlaps and player hits, publishes on vsync rise.
// Optional macro COLLISION_POS_CAPTURE_EN adds hit_x/hit_y capture of the first player collision per frame.
module sprite_collision_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic       display_on,
  input  logic       vsync,
  input  logic [8:0] hpos,
  input  logic [8:0] vpos,
  input  logic [3:0] gfx,
  input  logic       ack,
  output logic [5:0] collide,
  output logic [7:0] hit_count,
  output logic       irq
`ifdef COLLISION_POS_CAPTURE_EN
  ,
  output logic [8:0] hit_x,
  output logic [8:0] hit_y
`endif
);

  localparam int unsigned PAIR_W = 6;
  localparam int unsigned CNT_W  = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    WAIT_FRAME = 1'b0,
    RUN        = 1'b1
  } state_t;

  state_t            state, state_next;
  logic              vsync_q;
  logic [PAIR_W-1:0] work, work_next;
  logic [CNT_W-1:0]  work_cnt, cnt_next;
  logic [PAIR_W-1:0] collide_next;
  logic [CNT_W-1:0]  hit_next;
  logic              irq_next;

  logic [PAIR_W-1:0] ov;
  logic [PAIR_W-1:0] frame_ov;
  logic              vsync_rise;
  logic              hit_inc;
  logic [CNT_W-1:0]  cnt_sum;

  // Pairwise overlap, gated by the visible area
  always_comb begin
    ov[0] = display_on & gfx[0] & gfx[1];
    ov[1] = display_on & gfx[0] & gfx[2];
    ov[2] = display_on & gfx[0] & gfx[3];
    ov[3] = display_on & gfx[1] & gfx[2];
    ov[4] = display_on & gfx[1] & gfx[3];
    ov[5] = display_on & gfx[2] & gfx[3];
  end

  assign vsync_rise = vsync & ~vsync_q;
  assign hit_inc    = display_on & gfx[0] & (|gfx[3:1]);
  assign frame_ov   = work | ov;
  assign cnt_sum    = (hit_inc && (work_cnt != CNT_MAX)) ? CNT_W'(work_cnt + 1'b1) : work_cnt;

`ifdef COLLISION_POS_CAPTURE_EN
  logic [8:0] cap_x, cap_y, cap_x_next, cap_y_next;
  logic [8:0] hit_x_next, hit_y_next;
`else
  logic unused_pos;
  assign unused_pos = ^{hpos, vpos};
`endif

  // Next-state, accumulation and publish logic
  always_comb begin
    state_next   = state;
    work_next    = work;
    cnt_next     = work_cnt;
    collide_next = collide;
    hit_next     = hit_count;
    irq_next     = ack ? 1'b0 : irq;
`ifdef COLLISION_POS_CAPTURE_EN
    cap_x_next   = cap_x;
    cap_y_next   = cap_y;
    hit_x_next   = hit_x;
    hit_y_next   = hit_y;
`endif
    case (state)
      WAIT_FRAME: begin
        work_next = '0;
        cnt_next  = '0;
`ifdef COLLISION_POS_CAPTURE_EN
        cap_x_next = '0;
        cap_y_next = '0;
`endif
        if (vsync_rise) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (vsync_rise) begin
          collide_next = frame_ov;
          hit_next     = cnt_sum;
          irq_next     = |frame_ov;
          work_next    = '0;
          cnt_next     = '0;
`ifdef COLLISION_POS_CAPTURE_EN
          // A hit on the publishing cycle itself counts as the first one if none came earlier
          if (work_cnt != '0) begin
            hit_x_next = cap_x;
            hit_y_next = cap_y;
          end else if (hit_inc) begin
            hit_x_next = hpos;
            hit_y_next = vpos;
          end else begin
            hit_x_next = '0;
            hit_y_next = '0;
          end
          cap_x_next = '0;
          cap_y_next = '0;
`endif
        end else begin
          work_next = frame_ov;
          cnt_next  = cnt_sum;
`ifdef COLLISION_POS_CAPTURE_EN
          if (hit_inc && (work_cnt == '0)) begin
            cap_x_next = hpos;
            cap_y_next = vpos;
          end
`endif
        end
      end
      default: begin
        state_next = WAIT_FRAME;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= WAIT_FRAME;
      vsync_q   <= 1'b0;
      work      <= '0;
      work_cnt  <= '0;
      collide   <= '0;
      hit_count <= '0;
      irq       <= 1'b0;
    end else begin
      state     <= state_next;
      vsync_q   <= vsync;
      work      <= work_next;
      work_cnt  <= cnt_next;
      collide   <= collide_next;
      hit_count <= hit_next;
      irq       <= irq_next;
    end
  end

`ifdef COLLISION_POS_CAPTURE_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      cap_x <= '0;
      cap_y <= '0;
      hit_x <= '0;
      hit_y <= '0;
    end else begin
      cap_x <= cap_x_next;
      cap_y <= cap_y_next;
      hit_x <= hit_x_next;
      hit_y <= hit_y_next;
    end
  end
`endif

endmodule

// File: tb/tb_sprite_collision_unit.sv
// Directed, table-driven bench for sprite_collision_unit; checks frame publishes, irq/ack and reset corners.
module tb_sprite_collision_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       display_on;
  logic       vsync;
  logic [8:0] hpos, vpos;
  logic [3:0] gfx;
  logic       ack;
  logic [5:0] collide;
  logic [7:0] hit_count;
  logic       irq;
`ifdef COLLISION_POS_CAPTURE_EN
  logic [8:0] hit_x, hit_y;
`endif

  int tests = 0;
  int fails = 0;

  sprite_collision_unit dut (
    .clk        (clk),
    .reset      (reset),
    .display_on (display_on),
    .vsync      (vsync),
    .hpos       (hpos),
    .vpos       (vpos),
    .gfx        (gfx),
    .ack        (ack),
    .collide    (collide),
    .hit_count  (hit_count),
    .irq        (irq)
`ifdef COLLISION_POS_CAPTURE_EN
    ,
    .hit_x      (hit_x),
    .hit_y      (hit_y)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] g;
    logic       d;
    int         n;
    logic [8:0] h;
    logic [8:0] v;
    logic [5:0] e_col;
    int         e_hit;
    logic       e_irq;
  } vec_t;

  vec_t vecs[11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_frame(input logic [3:0] g, input logic d, input int n,
                           input logic [8:0] h, input logic [8:0] v);
    gfx = g; display_on = d; hpos = h; vpos = v;
    repeat (n) step();
  endtask

  task automatic vsync_pulse();
    gfx = 4'b0000; display_on = 1'b0; vsync = 1'b1;
    step();
    vsync = 1'b0;
    step();
  endtask

  task automatic check_out(input string tag, input int e_col, input int e_hit, input int e_irq);
    check({tag, ".collide"},   int'(collide),   e_col);
    check({tag, ".hit_count"}, int'(hit_count), e_hit);
    check({tag, ".irq"},       int'(irq),       e_irq);
  endtask

  initial begin
    vecs[0]  = '{4'b0011, 1'b1, 10,  9'd40,  9'd20, 6'b000001, 10,  1'b1};
    vecs[1]  = '{4'b1110, 1'b1, 300, 9'd7,   9'd9,  6'b111000, 0,   1'b1};
    vecs[2]  = '{4'b1111, 1'b1, 300, 9'd100, 9'd50, 6'b111111, 255, 1'b1};
    vecs[3]  = '{4'b0101, 1'b0, 50,  9'd3,   9'd4,  6'b000000, 0,   1'b0};
    vecs[4]  = '{4'b0101, 1'b1, 5,   9'd11,  9'd12, 6'b000010, 5,   1'b1};
    vecs[5]  = '{4'b1001, 1'b1, 7,   9'd300, 9'd200,6'b000100, 7,   1'b1};
    vecs[6]  = '{4'b0110, 1'b1, 3,   9'd1,   9'd2,  6'b001000, 0,   1'b1};
    vecs[7]  = '{4'b0000, 1'b1, 4,   9'd5,   9'd6,  6'b000000, 0,   1'b0};
    vecs[8]  = '{4'b0001, 1'b1, 4,   9'd5,   9'd6,  6'b000000, 0,   1'b0};
    vecs[9]  = '{4'b0011, 1'b1, 255, 9'd511, 9'd511,6'b000001, 255, 1'b1};
    vecs[10] = '{4'b0011, 1'b1, 254, 9'd8,   9'd9,  6'b000001, 254, 1'b1};

    reset = 1'b0; display_on = 1'b0; vsync = 1'b0;
    hpos = '0; vpos = '0; gfx = '0; ack = 1'b0;
    repeat (3) step();
    check_out("reset", 0, 0, 0);

    // First frame after release only arms
    reset = 1'b1;
    run_frame(4'b0011, 1'b1, 10, 9'd40, 9'd20);
    vsync_pulse();
    check_out("arm", 0, 0, 0);

    for (int i = 0; i < 11; i++) begin
      run_frame(vecs[i].g, vecs[i].d, vecs[i].n, vecs[i].h, vecs[i].v);
      vsync_pulse();
      check_out($sformatf("vec%0d", i), int'(vecs[i].e_col), vecs[i].e_hit, int'(vecs[i].e_irq));
`ifdef COLLISION_POS_CAPTURE_EN
      check($sformatf("vec%0d.hit_x", i), int'(hit_x), vecs[i].e_hit > 0 ? int'(vecs[i].h) : 0);
      check($sformatf("vec%0d.hit_y", i), int'(hit_y), vecs[i].e_hit > 0 ? int'(vecs[i].v) : 0);
`endif
    end

    // vsync held high: one publish at the rise, accumulation continues while high
    run_frame(4'b0011, 1'b1, 3, 9'd10, 9'd10);
    vsync = 1'b1;
    step();
    check_out("hold_rise", 1, 4, 1);
    repeat (19) step();
    check_out("hold_end", 1, 4, 1);
    vsync = 1'b0;
    run_frame(4'b0000, 1'b0, 1, 9'd0, 9'd0);
    vsync_pulse();
    check_out("hold_next", 1, 19, 1);

    // ack coincident with a nonzero publish: publish wins
    run_frame(4'b0011, 1'b1, 2, 9'd0, 9'd0);
    gfx = 4'b0000; display_on = 1'b0; vsync = 1'b1; ack = 1'b1;
    step();
    vsync = 1'b0; ack = 1'b0;
    check_out("ack_pub", 1, 2, 1);
    step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("ack_alone.irq", int'(irq), 0);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check_out("ack_idle", 1, 2, 0);

    // Reset on the vsync rise with work pending: no publish, back to arming
    run_frame(4'b0011, 1'b1, 2, 9'd0, 9'd0);
    vsync_pulse();
    check_out("pre_rst", 1, 2, 1);
    run_frame(4'b1111, 1'b1, 5, 9'd0, 9'd0);
    vsync = 1'b1; reset = 1'b0; ack = 1'b1;
    step();
    vsync = 1'b0; reset = 1'b1; ack = 1'b0;
    check_out("rst_vs", 0, 0, 0);
    run_frame(4'b0011, 1'b1, 4, 9'd0, 9'd0);
    vsync_pulse();
    check_out("rearm", 0, 0, 0);
    run_frame(4'b0011, 1'b1, 3, 9'd0, 9'd0);
    vsync_pulse();
    check_out("after_rearm", 1, 3, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
